os_systolic_engine: RTL and testbench
=====================================

// Module: os_systolic_engine
// PURPOSE
//   Output-stationary systolic GEMM tile engine: C[A_H][B_W] = sum_k A[:,k]*B[k,:], signed operands.
//   Generalises the fixed-flow array with an internal input skew, a K-length tile controller,
//   valid/ready input streaming and a row-serial valid/ready result drain.
//   Sits between the operand buffers and the result write-back path.
// PARAMETERS
//   A_H        16  rows of PEs (A vector length)
//   B_W        16  columns of PEs (B vector length)
//   WIDTH      8   signed operand width
//   ACC_WIDTH  32  signed accumulator width (>= 2*WIDTH)
//   K_W        16  width of k_len (max tile depth 2^K_W-1)
// PORTS
//   clk        in   1                 clock
//   rst_n      in   1                 async active-low reset
//   start      in   1                 begin tile; sampled only in IDLE
//   k_len      in   K_W               vectors in tile; sampled with start
//   in_valid   in   1                 A/B vector pair valid
//   in_ready   out  1                 engine accepts pair (state LOAD, count < k_len)
//   a_vec      in   A_H*WIDTH         column k of A, row i at [i*WIDTH +: WIDTH]
//   b_vec      in   B_W*WIDTH         row k of B, col j at [j*WIDTH +: WIDTH]
//   out_valid  out  1                 result row valid
//   out_ready  in   1                 consumer accepts row
//   out_row    out  $clog2(A_H)       index of row on out_data
//   out_data   out  B_W*ACC_WIDTH     C[out_row][j] at [j*ACC_WIDTH +: ACC_WIDTH]
//   out_sat    out  1                 some element in row saturated (0 when OS_SATURATE_EN undefined)
//   busy       out  1                 state != IDLE
// BEHAVIOUR
//   Reset: state IDLE; in_ready, out_valid, out_sat, busy = 0; out_row, out_data, all accs, skew regs = 0.
//   FSM: IDLE -start-> LOAD (all accs cleared same edge; k_len==0 -> FLUSH directly)
//        LOAD: pair accepted on in_valid&in_ready; after k_len accepts -> FLUSH
//        FLUSH: exactly A_H+B_W cycles (counter 0..A_H+B_W-1), then -> DRAIN
//        DRAIN: rows 0..A_H-1 in order, one per out_valid&out_ready; after row A_H-1 -> IDLE.
//   Skew: a row i delayed i cycles, b col j delayed j cycles (shift regs); any cycle without
//     an accepted pair (bubble, FLUSH) injects zeros, so input stalls never corrupt results.
//   PE(i,j): registers a east, b south, acc += a*b every cycle; element k of a tile reaches
//     PE(i,j) i+j+1 cycles after acceptance.
//   Arithmetic: product 2*WIDTH signed, sign-extended to ACC_WIDTH; wraps mod 2^ACC_WIDTH.
//   Drain: out_data/out_row/out_sat stable while out_valid & !out_ready; first out_valid
//     the cycle after FLUSH ends.
//   start while busy: ignored. in_valid outside LOAD: ignored (in_ready=0).
//   Reset mid-tile: immediate abort to reset state; no partial output.
// CONFIGURATION
//   OS_SATURATE_EN defined: acc clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; per-PE sticky
//     sat bit (cleared at start); out_sat = OR of the row's sat bits.
//   Undefined: wrap-around accumulation; out_sat tied 0; no sat bits synthesised.
// STRUCTURE
//   Package os_engine_pkg: state enum (IDLE/LOAD/FLUSH/DRAIN), acc min/max constants,
//     flush-length function (A_H+B_W).
//   Sub-module os_pe: one PE (forward regs, MAC, clear, optional saturation + sat bit).
//   Top: skew shift registers, FSM + counters, drain row mux; PEs via 2-D generate.
// TESTING (A_H=B_W=4, WIDTH=8, ACC_WIDTH=32)
//   Reset: rst_n low -> busy=0, in_ready=0, out_valid=0, out_data=0.
//   Identity: k_len=4, A=I, B[k][j]=k*4+j -> rows out 0..3 equal B rows; out_sat=0.
//   Bubbles: k_len=3, all a=2,b=3 with in_valid low 2 cycles between pairs -> every C=18.
//   Extremes: k_len=2, a=-128,b=-128 -> C=32768; a=-128,b=127 -> C=-32512.
//   Backpressure: out_ready low 5 cycles on row 1 -> out_row=1 and out_data held; rows 0..3 once.
//   Abort/start: start during DRAIN ignored; rst_n low in LOAD, then k_len=1 a=b=1 -> all C=1.
//   OS_SATURATE_EN with ACC_WIDTH=16: k_len=3, a=b=-128 -> C=32767, out_sat=1 every row.

Source files
------------

// File: rtl/os_systolic_engine_pkg.sv
// rtl/os_systolic_engine_pkg.sv - shared types and helpers for the output-stationary systolic engine
// Purpose : FSM state encoding, flush-length helper and accumulator clamp limits.
// Contents: state_t, flush_len(), acc_max(), acc_min().
package os_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Cycles needed after the last accepted pair before the far corner PE is settled.
  function automatic int flush_len(input int a_h, input int b_w);
    return a_h + b_w;
  endfunction

  // Bit patterns of the most positive / most negative w-bit two's complement values.
  function automatic logic [63:0] acc_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] acc_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/os_systolic_engine_if.sv
// rtl/os_systolic_engine_if.sv - operand stream, control and result drain bundle
// Purpose : groups start/k_len, the A/B valid/ready input stream, the row result stream and busy.
// Modports: master (operand/consumer side), slave (engine side).
interface os_systolic_engine_if #(
  parameter int A_H       = 16,
  parameter int B_W       = 16,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32,
  parameter int K_W       = 16
);
  logic                         start;
  logic [K_W-1:0]               k_len;
  logic                         in_valid;
  logic                         in_ready;
  logic [A_H*WIDTH-1:0]         a_vec;
  logic [B_W*WIDTH-1:0]         b_vec;
  logic                         out_valid;
  logic                         out_ready;
  logic [$clog2(A_H)-1:0]       out_row;
  logic [B_W*ACC_WIDTH-1:0]     out_data;
  logic                         out_sat;
  logic                         busy;

  modport master (
    output start, k_len, in_valid, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, out_row, out_data, out_sat, busy
  );

  modport slave (
    input  start, k_len, in_valid, a_vec, b_vec, out_ready,
    output in_ready, out_valid, out_row, out_data, out_sat, busy
  );
endinterface

// File: rtl/os_systolic_engine_pe.sv
// rtl/os_systolic_engine_pe.sv - one output-stationary MAC processing element
// Purpose : acc += a*b every cycle, synchronous clear on tile start.
// Ports   : clk, rst_n, i_clr, i_a, i_b (signed operands), o_acc (accumulator),
//           o_sat (sticky saturation flag, only when OS_SATURATE_EN is defined).
// Config  : OS_SATURATE_EN selects clamping accumulation; otherwise wrap-around.
module os_pe
  import os_engine_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
`ifdef OS_SATURATE_EN
  output logic                    o_sat,
`endif
  output logic [ACC_WIDTH-1:0]    o_acc
);

  logic signed [2*WIDTH-1:0]   w_prod;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic [ACC_WIDTH-1:0]        w_acc_next;
  logic [ACC_WIDTH-1:0]        r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = ACC_WIDTH'(w_prod);

`ifdef OS_SATURATE_EN
  localparam logic [63:0] MAX64 = acc_max(ACC_WIDTH);
  localparam logic [63:0] MIN64 = acc_min(ACC_WIDTH);

  logic [ACC_WIDTH:0] w_sum;
  logic               w_ovf;
  logic               r_sat;

  // One guard bit: overflow when the two top bits of the widened sum disagree.
  assign w_sum      = {r_acc[ACC_WIDTH-1], r_acc} + {w_prod_ext[ACC_WIDTH-1], w_prod_ext};
  assign w_ovf      = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
  assign w_acc_next = !w_ovf ? w_sum[ACC_WIDTH-1:0]
                    : (w_sum[ACC_WIDTH] ? MIN64[ACC_WIDTH-1:0] : MAX64[ACC_WIDTH-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_sat <= 1'b0;
    else if (i_clr) r_sat <= 1'b0;
    else            r_sat <= r_sat | w_ovf;
  end

  assign o_sat = r_sat;
`else
  assign w_acc_next = r_acc + w_prod_ext;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else            r_acc <= w_acc_next;
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/os_systolic_engine.sv
// rtl/os_systolic_engine.sv - output-stationary systolic GEMM tile engine
// Purpose : C[A_H][B_W] = sum_k A[:,k]*B[k,:] with input skew, K-length tile control and
//           row-serial result drain.
// Ports   : clk, rst_n (async active-low); bus (slave): start/k_len, in_valid/in_ready/a_vec/b_vec,
//           out_valid/out_ready/out_row/out_data/out_sat, busy.
// Config  : OS_SATURATE_EN enables saturating accumulation and out_sat.
module os_systolic_engine
  import os_engine_pkg::*;
#(
  parameter int A_H       = 16,
  parameter int B_W       = 16,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32,
  parameter int K_W       = 16
) (
  input logic                clk,
  input logic                rst_n,
  os_systolic_engine_if.slave bus
);

  localparam int FLUSH_N = flush_len(A_H, B_W);
  localparam int FW      = $clog2(FLUSH_N);
  localparam int RW      = $clog2(A_H);

  state_t         r_state, w_next;
  logic [K_W-1:0] r_klen, r_cnt;
  logic [FW-1:0]  r_fcnt;
  logic [RW-1:0]  r_row;
  logic           w_in_ready, w_accept, w_clr, w_flush_last, w_drain_fire, w_last_row;

  logic [WIDTH-1:0]     w_a_pe [A_H][B_W];
  logic [WIDTH-1:0]     w_b_pe [A_H][B_W];
  logic [ACC_WIDTH-1:0] w_acc  [A_H][B_W];
  logic [B_W*ACC_WIDTH-1:0] w_out_data;

  assign w_accept     = w_in_ready & bus.in_valid;
  assign w_clr        = (r_state == S_IDLE) & bus.start;
  assign w_flush_last = (r_fcnt == FW'(FLUSH_N - 1));
  assign w_drain_fire = (r_state == S_DRAIN) & bus.out_ready;
  assign w_last_row   = (r_row == RW'(A_H - 1));

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = (bus.k_len == '0) ? S_FLUSH : S_LOAD;
      S_LOAD: begin
        w_in_ready = (r_cnt < r_klen);
        if (w_accept && ((r_cnt + K_W'(1)) == r_klen)) w_next = S_FLUSH;
      end
      S_FLUSH: if (w_flush_last) w_next = S_DRAIN;
      S_DRAIN: if (w_drain_fire && w_last_row) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_klen  <= '0;
      r_cnt   <= '0;
      r_fcnt  <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_next;
      if (w_clr) begin
        r_klen <= bus.k_len;
        r_cnt  <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + K_W'(1);
      end
      if (r_state == S_FLUSH && !w_flush_last) r_fcnt <= r_fcnt + FW'(1);
      else                                     r_fcnt <= '0;
      if (w_drain_fire) r_row <= w_last_row ? '0 : r_row + RW'(1);
    end
  end

  // Input skew: row i / column j see i / j extra register stages. Stage 0 loads
  // zero whenever no pair is accepted, so bubbles and flush cycles add nothing.
  for (genvar gi = 0; gi < A_H; gi++) begin : g_a_skew
    logic [WIDTH-1:0] r_sk [0:gi];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d <= gi; d++) r_sk[d] <= '0;
      end else begin
        r_sk[0] <= w_accept ? bus.a_vec[gi*WIDTH +: WIDTH] : '0;
        for (int d = 1; d <= gi; d++) r_sk[d] <= r_sk[d-1];
      end
    end
    assign w_a_pe[gi][0] = r_sk[gi];
  end

  for (genvar gj = 0; gj < B_W; gj++) begin : g_b_skew
    logic [WIDTH-1:0] r_sk [0:gj];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d <= gj; d++) r_sk[d] <= '0;
      end else begin
        r_sk[0] <= w_accept ? bus.b_vec[gj*WIDTH +: WIDTH] : '0;
        for (int d = 1; d <= gj; d++) r_sk[d] <= r_sk[d-1];
      end
    end
    assign w_b_pe[0][gj] = r_sk[gj];
  end

`ifdef OS_SATURATE_EN
  logic w_sat [A_H][B_W];
`endif

  // PE grid. Operand forwarding registers exist only where a downstream PE consumes them.
  for (genvar gi = 0; gi < A_H; gi++) begin : g_row
    for (genvar gj = 0; gj < B_W; gj++) begin : g_col
      if (gj > 0) begin : g_a_fwd
        logic [WIDTH-1:0] r_a;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_a <= '0;
          else        r_a <= w_a_pe[gi][gj-1];
        end
        assign w_a_pe[gi][gj] = r_a;
      end
      if (gi > 0) begin : g_b_fwd
        logic [WIDTH-1:0] r_b;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_b <= '0;
          else        r_b <= w_b_pe[gi-1][gj];
        end
        assign w_b_pe[gi][gj] = r_b;
      end
      os_pe #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .i_a   (w_a_pe[gi][gj]),
        .i_b   (w_b_pe[gi][gj]),
`ifdef OS_SATURATE_EN
        .o_sat (w_sat[gi][gj]),
`endif
        .o_acc (w_acc[gi][gj])
      );
    end
  end

  always_comb begin
    w_out_data = '0;
    if (r_state == S_DRAIN) begin
      for (int j = 0; j < B_W; j++) w_out_data[j*ACC_WIDTH +: ACC_WIDTH] = w_acc[r_row][j];
    end
  end

`ifdef OS_SATURATE_EN
  logic w_row_sat;
  always_comb begin
    w_row_sat = 1'b0;
    if (r_state == S_DRAIN) begin
      for (int j = 0; j < B_W; j++) w_row_sat = w_row_sat | w_sat[r_row][j];
    end
  end
  assign bus.out_sat = w_row_sat;
`else
  assign bus.out_sat = 1'b0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DRAIN);
  assign bus.out_row   = r_row;
  assign bus.out_data  = w_out_data;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_os_systolic_engine.sv
// tb/tb_os_systolic_engine.sv - self-checking bench for os_systolic_engine (A_H=B_W=4)
module tb_os_systolic_engine;
  localparam int AH = 4;
  localparam int BW = 4;
  localparam int W  = 8;
`ifdef OS_SATURATE_EN
  localparam int ACC = 16;
`else
  localparam int ACC = 32;
`endif
  localparam int KW = 16;

  typedef struct {
    int                   row;
    logic [BW*ACC-1:0]    data;
    logic                 sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   A_m [0:7][0:AH-1];
  int   B_m [0:7][0:BW-1];

  always #5 clk = ~clk;

  os_systolic_engine_if #(.A_H(AH), .B_W(BW), .WIDTH(W), .ACC_WIDTH(ACC), .K_W(KW)) bus ();

  os_systolic_engine #(.A_H(AH), .B_W(BW), .WIDTH(W), .ACC_WIDTH(ACC), .K_W(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: straightforward triple loop, clamping per step when saturation is built in.
  task automatic push_expected(input int k);
    longint mx, mn, s;
    exp_t   e;
    mx = (longint'(1) << (ACC - 1)) - 1;
    mn = -(longint'(1) << (ACC - 1));
    for (int i = 0; i < AH; i++) begin
      e.row  = i;
      e.data = '0;
      e.sat  = 1'b0;
      for (int j = 0; j < BW; j++) begin
        s = 0;
        for (int p = 0; p < k; p++) begin
          s = s + longint'(A_m[p][i]) * longint'(B_m[p][j]);
`ifdef OS_SATURATE_EN
          if (s > mx) begin s = mx; e.sat = 1'b1; end
          if (s < mn) begin s = mn; e.sat = 1'b1; end
`endif
        end
        e.data[j*ACC +: ACC] = s[ACC-1:0];
      end
      sb.push_back(e);
    end
  endtask

  task automatic drive_pair(input int p);
    int t;
    for (int i = 0; i < AH; i++) begin t = A_m[p][i]; bus.a_vec[i*W +: W] = t[W-1:0]; end
    for (int j = 0; j < BW; j++) begin t = B_m[p][j]; bus.b_vec[j*W +: W] = t[W-1:0]; end
    bus.in_valid = 1'b1;
  endtask

  // Runs one tile; lat = cycles from last acceptance to first out_valid.
  task automatic load_tile(input int k, input int gap, output int lat);
    int n;
    bus.k_len = KW'(k);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int p = 0; p < k; p++) begin
      drive_pair(p);
      n = 0;
      while (!bus.in_ready && n < 50) begin tick(); n++; end
      if (n >= 50) begin
        errors++;
        $display("FAIL in_ready_timeout: in_ready=%0b required 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      if (p < k - 1) repeat (gap) tick();
    end
    push_expected(k);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic drain(input int stall_row, input int stall_cyc);
    exp_t e;
    int   n;
    for (int r = 0; r < AH; r++) begin
      e = sb.pop_front();
      bus.out_ready = (r != stall_row);
      n = 0;
      while (!bus.out_valid && n < 100) begin tick(); n++; end
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL out_valid_timeout row %0d: out_valid=%0b required 1", r, bus.out_valid);
        bus.out_ready = 1'b0;
        return;
      end
      checks++;
      if (bus.out_row !== 2'(e.row) || bus.out_data !== e.data || bus.out_sat !== e.sat) begin
        errors++;
        $display("FAIL row_%0d: row=%0d data=%h sat=%0b required row=%0d data=%h sat=%0b",
                 r, bus.out_row, bus.out_data, bus.out_sat, e.row, e.data, e.sat);
      end
      if (r == stall_row) begin
        repeat (stall_cyc) tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_row !== 2'(e.row) || bus.out_data !== e.data) begin
          errors++;
          $display("FAIL backpressure_hold: valid=%0b row=%0d data=%h required 1 %0d %h",
                   bus.out_valid, bus.out_row, bus.out_data, e.row, e.data);
        end
        bus.out_ready = 1'b1;
      end
      tick();
    end
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: out_valid=%0b busy=%0b required 0 0", bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_data !== '0 || bus.out_row !== '0 || bus.out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%0b in_ready=%0b out_valid=%0b data=%h row=%0d sat=%0b required all 0",
               bus.busy, bus.in_ready, bus.out_valid, bus.out_data, bus.out_row, bus.out_sat);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_identity();
    int lat;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < AH; i++) A_m[p][i] = (i == p) ? 1 : 0;
      for (int j = 0; j < BW; j++) B_m[p][j] = p * 4 + j;
    end
    load_tile(4, 0, lat);
    checks++;
    if (lat != AH + BW) begin
      errors++;
      $display("FAIL first_valid_latency: %0d cycles required %0d", lat, AH + BW);
    end
    drain(-1, 0);
  endtask

  task automatic test_bubbles();
    int lat;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < AH; i++) A_m[p][i] = 2;
      for (int j = 0; j < BW; j++) B_m[p][j] = 3;
    end
    load_tile(3, 2, lat);
    drain(-1, 0);
  endtask

  task automatic test_extremes();
    int lat;
    // in_valid while idle must not be taken.
    for (int i = 0; i < AH; i++) A_m[0][i] = 127;
    for (int j = 0; j < BW; j++) B_m[0][j] = 127;
    drive_pair(0);
    repeat (3) begin
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_in_ready: in_ready=%0b required 0", bus.in_ready);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < AH; i++) A_m[p][i] = -128;
      for (int j = 0; j < BW; j++) B_m[p][j] = -128;
    end
    load_tile(2, 0, lat);
    drain(-1, 0);
    for (int p = 0; p < 2; p++) begin
      for (int j = 0; j < BW; j++) B_m[p][j] = 127;
    end
    load_tile(2, 1, lat);
    drain(-1, 0);
  endtask

  task automatic test_backpressure();
    int lat;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < AH; i++) A_m[p][i] = $urandom_range(255) - 128;
      for (int j = 0; j < BW; j++) B_m[p][j] = $urandom_range(255) - 128;
    end
    load_tile(3, 0, lat);
    drain(1, 5);
  endtask

  task automatic test_abort_start();
    int lat;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < AH; i++) A_m[p][i] = i + p - 2;
      for (int j = 0; j < BW; j++) B_m[p][j] = 5 - j * p;
    end
    load_tile(2, 0, lat);
    bus.out_ready = 1'b0;
    bus.k_len = KW'(1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drain(-1, 0);
    // Reset in the middle of LOAD.
    bus.k_len = KW'(2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    drive_pair(0);
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: busy=%0b in_ready=%0b out_valid=%0b required 0 0 0",
               bus.busy, bus.in_ready, bus.out_valid);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < AH; i++) A_m[0][i] = 1;
    for (int j = 0; j < BW; j++) B_m[0][j] = 1;
    load_tile(1, 0, lat);
    drain(-1, 0);
  endtask

  task automatic test_saturate();
    int lat;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < AH; i++) A_m[p][i] = -128;
      for (int j = 0; j < BW; j++) B_m[p][j] = -128;
    end
    load_tile(3, 0, lat);
    drain(-1, 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.in_valid  = 1'b0;
    bus.a_vec     = '0;
    bus.b_vec     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_identity();
    test_bubbles();
    test_extremes();
    test_backpressure();
    test_abort_start();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
